conv2_seq_ctrl: RTL and testbench

- Sequencer for the second convolution layer datapath (4 input channels × 8 output channels, 3-tap kernels).
- On a start pulse it runs three phases:
  - reads all weights and biases out of the single-port parameter BRAMs and gives a capture strobe with each word;
  - streams activation addresses to the layer-1 output buffer, gated by upstream availability, and drives the convolver clock-enable aligned to BRAM read latency;
  - waits for the datapath end flag, then reports done.
- Replaces the free-running address counters with a controlled, restartable schedule.

---
 rtl/conv2_pkg.sv | 26 ++
 rtl/lat_pipe.sv | 28 ++
 rtl/conv2_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_conv2_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// conv2_pkg: shared constants and state encoding for the layer-2 convolution
// sequencer. Parameter BRAM depths come from the layer geometry
// (3-tap kernels, 4 input channels, 8 output channels).
package conv2_pkg;

  localparam int K       = 3;
  localparam int INCHAN  = 4;
  localparam int OUTCHAN = 8;

  localparam int W_WORDS   = K * INCHAN * OUTCHAN;  // weight words (96)
  localparam int B_WORDS   = INCHAN * OUTCHAN;      // bias words (32)
  localparam int N_ACT_DEF = 2562;                  // activations per channel

  localparam int WA_W = $clog2(W_WORDS);    // weight address width
  localparam int BA_W = $clog2(B_WORDS);    // bias address width
  localparam int AA_W = $clog2(N_ACT_DEF);  // activation address width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/lat_pipe.sv
// lat_pipe: LAT-deep shift register used to line an {enable, address} pair
// up with the data a BRAM returns LAT cycles after the read is issued.
// Ports: clk, global_rst (async, active-high), d (word entering the pipe),
// q (word delayed LAT cycles).
module lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         global_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [LAT-1:0][W-1:0] pipe;

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[LAT-1];

endmodule

// File: rtl/conv2_seq_ctrl.sv
// conv2_seq_ctrl: restartable sequencer for the layer-2 convolver.
// A start pulse runs LOAD (read every weight and bias word, with capture
// strobes aligned to BRAM latency), RUN (stream activation addresses while
// upstream data is available, with conv_ce aligned to returned data) and
// DRAIN (wait for the datapath end flag, bounded by DRAIN_MAX), then pulses
// done.
// Ports:
//   clk, global_rst (async, active-high)
//   start, act_avail, conv_end              control inputs
//   wgt_en/wgt_addr, wgt_cap/wgt_idx        weight BRAM read and capture
//   bias_en/bias_addr, bias_cap/bias_idx    bias BRAM read and capture
//   act_en/act_addr, conv_ce                activation stream and convolver CE
//   busy, done, err_timeout                 status
module conv2_seq_ctrl
  import conv2_pkg::*;
#(
  parameter int N_ACT     = N_ACT_DEF,
  parameter int BRAM_LAT  = 1,
  parameter int DRAIN_MAX = 64
) (
  input  logic            clk,
  input  logic            global_rst,
  input  logic            start,
  input  logic            act_avail,
  input  logic            conv_end,
  output logic            wgt_en,
  output logic [WA_W-1:0] wgt_addr,
  output logic            wgt_cap,
  output logic [WA_W-1:0] wgt_idx,
  output logic            bias_en,
  output logic [BA_W-1:0] bias_addr,
  output logic            bias_cap,
  output logic [BA_W-1:0] bias_idx,
  output logic            act_en,
  output logic [AA_W-1:0] act_addr,
  output logic            conv_ce,
  output logic            busy,
  output logic            done,
  output logic            err_timeout
);

  // LOAD runs W_WORDS read cycles plus BRAM_LAT cycles so the last word lands
  localparam int LW = $clog2(W_WORDS + BRAM_LAT + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  localparam logic [LW-1:0]   LD_LAST  = LW'(W_WORDS + BRAM_LAT - 1);
  localparam logic [LW-1:0]   LD_W     = LW'(W_WORDS);
  localparam logic [LW-1:0]   LD_B     = LW'(B_WORDS);
  localparam logic [AA_W-1:0] ACT_LAST = AA_W'(N_ACT - 1);
  localparam logic [DW-1:0]   DR_LAST  = DW'(DRAIN_MAX - 1);

  state_t          state, state_nx;
  logic [LW-1:0]   ld_cnt, ld_cnt_nx;
  logic [DW-1:0]   dr_cnt, dr_cnt_nx;
  logic [AA_W-1:0] act_addr_nx;
  logic            err_nx;
  logic            wgt_en_nx, bias_en_nx;
  logic [WA_W-1:0] wgt_addr_nx;
  logic [BA_W-1:0] bias_addr_nx;
  logic [WA_W:0]   wgt_q;
  logic [BA_W:0]   bias_q;

  // The one deliberately combinational output: a stalled cycle never issues.
  assign act_en = (state == S_RUN) & act_avail;

  always_comb begin
    state_nx    = state;
    ld_cnt_nx   = ld_cnt;
    dr_cnt_nx   = dr_cnt;
    act_addr_nx = act_addr;
    err_nx      = err_timeout;
    case (state)
      S_IDLE: begin
        ld_cnt_nx   = '0;
        dr_cnt_nx   = '0;
        act_addr_nx = '0;
        if (start) begin
          state_nx = S_LOAD;
          err_nx   = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_cnt == LD_LAST) begin
          state_nx  = S_RUN;
          ld_cnt_nx = '0;
        end else begin
          ld_cnt_nx = ld_cnt + 1'b1;
        end
      end
      S_RUN: begin
        // the address that issues the last word stays put for DRAIN
        if (act_avail) begin
          if (act_addr == ACT_LAST) state_nx = S_DRAIN;
          else                      act_addr_nx = act_addr + 1'b1;
        end
      end
      S_DRAIN: begin
        dr_cnt_nx = dr_cnt + 1'b1;
        // conv_end wins a tie with the timeout
        if (conv_end) begin
          state_nx = S_DONE;
        end else if (dr_cnt == DR_LAST) begin
          state_nx = S_DONE;
          err_nx   = 1'b1;
        end
        if (state_nx == S_DONE) begin
          act_addr_nx = '0;
          dr_cnt_nx   = '0;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // read strobes are registered from next-state values so they appear
    // in the first LOAD cycle without any path from the inputs
    wgt_en_nx    = (state_nx == S_LOAD) && (ld_cnt_nx < LD_W);
    wgt_addr_nx  = wgt_en_nx ? ld_cnt_nx[WA_W-1:0] : '0;
    bias_en_nx   = (state_nx == S_LOAD) && (ld_cnt_nx < LD_B);
    bias_addr_nx = bias_en_nx ? ld_cnt_nx[BA_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state       <= S_IDLE;
      ld_cnt      <= '0;
      dr_cnt      <= '0;
      act_addr    <= '0;
      err_timeout <= 1'b0;
      wgt_en      <= 1'b0;
      wgt_addr    <= '0;
      bias_en     <= 1'b0;
      bias_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      ld_cnt      <= ld_cnt_nx;
      dr_cnt      <= dr_cnt_nx;
      act_addr    <= act_addr_nx;
      err_timeout <= err_nx;
      wgt_en      <= wgt_en_nx;
      wgt_addr    <= wgt_addr_nx;
      bias_en     <= bias_en_nx;
      bias_addr   <= bias_addr_nx;
      busy        <= (state_nx != S_IDLE);
      done        <= (state_nx == S_DONE);
    end
  end

  lat_pipe #(.LAT(BRAM_LAT), .W(WA_W + 1)) u_wgt_pipe (
    .clk        (clk),
    .global_rst (global_rst),
    .d          ({wgt_en, wgt_addr}),
    .q          (wgt_q)
  );
  assign {wgt_cap, wgt_idx} = wgt_q;

  lat_pipe #(.LAT(BRAM_LAT), .W(BA_W + 1)) u_bias_pipe (
    .clk        (clk),
    .global_rst (global_rst),
    .d          ({bias_en, bias_addr}),
    .q          (bias_q)
  );
  assign {bias_cap, bias_idx} = bias_q;

  lat_pipe #(.LAT(BRAM_LAT), .W(1)) u_ce_pipe (
    .clk        (clk),
    .global_rst (global_rst),
    .d          (act_en),
    .q          (conv_ce)
  );

endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Bench for conv2_seq_ctrl: two instances (BRAM_LAT=1 and 2) driven through
// directed passes with random stall/end-flag stimulus, compared cycle by
// cycle against a schedule computed from the layer rules.
module tb_conv2_seq_ctrl;

  localparam int NA   = 2562;
  localparam int NW   = 96;
  localparam int NB   = 32;
  localparam int DMAX = 64;

  typedef struct packed {
    logic        wgt_en;
    logic [6:0]  wgt_addr;
    logic        wgt_cap;
    logic [6:0]  wgt_idx;
    logic        bias_en;
    logic [4:0]  bias_addr;
    logic        bias_cap;
    logic [4:0]  bias_idx;
    logic        act_en;
    logic [11:0] act_addr;
    logic        conv_ce;
    logic        busy;
    logic        done;
    logic        err_timeout;
  } out_t;

  logic clk = 1'b0;
  logic global_rst, start1, start2, act_avail, conv_end;

  logic wgt_en1, wgt_cap1, bias_en1, bias_cap1, act_en1, conv_ce1, busy1, done1, err1;
  logic [6:0] wgt_addr1, wgt_idx1;
  logic [4:0] bias_addr1, bias_idx1;
  logic [11:0] act_addr1;
  logic wgt_en2, wgt_cap2, bias_en2, bias_cap2, act_en2, conv_ce2, busy2, done2, err2;
  logic [6:0] wgt_addr2, wgt_idx2;
  logic [4:0] bias_addr2, bias_idx2;
  logic [11:0] act_addr2;
  out_t o1, o2;

  int checks = 0;
  int failures = 0;
  int bad [10];
  int f_c [10];
  logic [31:0] f_o [10];
  logic [31:0] f_e [10];
  bit ea_h [0:9999];
  bit prev_err = 1'b0;
  string cat [10] = '{"wgt_rd", "wgt_cap", "bias_rd", "bias_cap", "act_en",
                      "act_addr", "conv_ce", "busy", "done", "err_timeout"};

  always #5 clk = ~clk;

  conv2_seq_ctrl #(.BRAM_LAT(1)) dut (
    .clk(clk), .global_rst(global_rst), .start(start1), .act_avail(act_avail),
    .conv_end(conv_end), .wgt_en(wgt_en1), .wgt_addr(wgt_addr1), .wgt_cap(wgt_cap1),
    .wgt_idx(wgt_idx1), .bias_en(bias_en1), .bias_addr(bias_addr1), .bias_cap(bias_cap1),
    .bias_idx(bias_idx1), .act_en(act_en1), .act_addr(act_addr1), .conv_ce(conv_ce1),
    .busy(busy1), .done(done1), .err_timeout(err1)
  );

  conv2_seq_ctrl #(.BRAM_LAT(2)) dut2 (
    .clk(clk), .global_rst(global_rst), .start(start2), .act_avail(act_avail),
    .conv_end(conv_end), .wgt_en(wgt_en2), .wgt_addr(wgt_addr2), .wgt_cap(wgt_cap2),
    .wgt_idx(wgt_idx2), .bias_en(bias_en2), .bias_addr(bias_addr2), .bias_cap(bias_cap2),
    .bias_idx(bias_idx2), .act_en(act_en2), .act_addr(act_addr2), .conv_ce(conv_ce2),
    .busy(busy2), .done(done2), .err_timeout(err2)
  );

  assign o1 = {wgt_en1, wgt_addr1, wgt_cap1, wgt_idx1, bias_en1, bias_addr1, bias_cap1,
               bias_idx1, act_en1, act_addr1, conv_ce1, busy1, done1, err1};
  assign o2 = {wgt_en2, wgt_addr2, wgt_cap2, wgt_idx2, bias_en2, bias_addr2, bias_cap2,
               bias_idx2, act_en2, act_addr2, conv_ce2, busy2, done2, err2};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic note(input int k, input int c, input logic [31:0] obs, input logic [31:0] exp);
    if (obs !== exp) begin
      if (bad[k] == 0) begin
        f_c[k] = c; f_o[k] = obs; f_e[k] = exp;
      end
      bad[k]++;
    end
  endtask

  // One layer pass. end_dly: cycles from the last issued activation to the
  // conv_end pulse (outside 1..DMAX means never). abort_at: activation
  // address at which reset is asserted (-1 = none).
  task automatic run_pass(input string name, input int sel, input int mode,
                          input int end_dly, input bit glitch, input int abort_at);
    int lat, c_run, issued, c_last, c_done, nw, nb, nce, nd;
    bit tmo, aborted, av, st, ew, eb, ea, ec;
    out_t o;
    lat = sel ? 2 : 1;
    c_run = 1 + NW + lat;
    issued = 0; c_last = -1; c_done = -1;
    nw = 0; nb = 0; nce = 0; nd = 0;
    tmo = (end_dly < 1) || (end_dly > DMAX);
    aborted = 1'b0;
    for (int k = 0; k < 10; k++) bad[k] = 0;
    for (int c = 0; ; c++) begin
      st = (c == 0) || (glitch && (c == 50 || c == c_run + 100));
      case (mode)
        0:       av = 1'b1;
        1:       av = (c < c_run) || (((c - c_run) % 10) < 7);
        default: av = ($urandom_range(0, 3) != 0);
      endcase
      if (c_last >= 0) conv_end = (c == c_last + end_dly);
      else             conv_end = (mode == 2) && ($urandom_range(0, 19) == 0);
      act_avail = av;
      start1 = st && (sel == 0);
      start2 = st && (sel != 0);
      if (abort_at >= 0 && c >= c_run && issued == abort_at) begin
        global_rst = 1'b1; conv_end = 1'b0; start1 = 1'b0; start2 = 1'b0;
        @(negedge clk);
        o = sel ? o2 : o1;
        chk({name, "_rst_outputs"}, 64'(o), 64'd0);
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          if (i == 1) global_rst = 1'b0;
          @(negedge clk);
          o = sel ? o2 : o1;
          chk({name, "_idle_no_done"}, 64'(o), 64'd0);
        end
        @(posedge clk); #1;
        aborted = 1'b1;
        prev_err = 1'b0;
        break;
      end
      @(negedge clk);
      o = sel ? o2 : o1;
      ew = (c >= 1) && (c <= NW);
      eb = (c >= 1) && (c <= NB);
      ea = (c >= c_run) && (c_last < 0) && av;
      ea_h[c] = ea;
      note(0, c, 32'(o.wgt_en), 32'(ew));
      if (ew) note(0, c, 32'(o.wgt_addr), 32'(c - 1));
      ec = (c >= 1 + lat) && (c <= NW + lat);
      note(1, c, 32'(o.wgt_cap), 32'(ec));
      if (ec) note(1, c, 32'(o.wgt_idx), 32'(c - lat - 1));
      note(2, c, 32'(o.bias_en), 32'(eb));
      note(2, c, 32'(o.bias_addr), eb ? 32'(c - 1) : 32'd0);
      ec = (c >= 1 + lat) && (c <= NB + lat);
      note(3, c, 32'(o.bias_cap), 32'(ec));
      if (ec) note(3, c, 32'(o.bias_idx), 32'(c - lat - 1));
      note(4, c, 32'(o.act_en), 32'(ea));
      if (ea) note(5, c, 32'(o.act_addr), 32'(issued));
      note(5, c, 32'(o.act_addr <= 12'(NA - 1)), 32'd1);
      if (c == c_done) note(5, c, 32'(o.act_addr), 32'd0);
      note(6, c, 32'(o.conv_ce), (c >= lat) ? 32'(ea_h[c - lat]) : 32'd0);
      note(7, c, 32'(o.busy), 32'((c >= 1) && (c_done < 0 || c <= c_done)));
      note(8, c, 32'(o.done), 32'(c == c_done));
      if (c == 0) note(9, c, 32'(o.err_timeout), 32'(prev_err));
      else        note(9, c, 32'(o.err_timeout), 32'(c_done >= 0 && c >= c_done && tmo));
      nw += int'(o.wgt_cap); nb += int'(o.bias_cap);
      nce += int'(o.conv_ce); nd += int'(o.done);
      if (ea) begin
        issued++;
        if (issued == NA) begin
          c_last = c;
          c_done = tmo ? c + DMAX + 1 : c + end_dly + 1;
        end
      end
      @(posedge clk); #1;
      if (c_done >= 0 && c == c_done + 2) break;
      if (c >= 9000) begin
        chk({name, "_pass_bound"}, 64'd0, 64'd1);
        break;
      end
    end
    start1 = 1'b0; start2 = 1'b0; conv_end = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      assert (bad[k] == 0) else begin
        failures++;
        $error("FAIL %s.%s bad_cycles=%0d required=0 first_cycle=%0d observed=%0d expected=%0d",
               name, cat[k], bad[k], f_c[k], f_o[k], f_e[k]);
      end
    end
    if (!aborted) begin
      chk({name, "_wgt_cap_count"}, 64'(nw), 64'(NW));
      chk({name, "_bias_cap_count"}, 64'(nb), 64'(NB));
      chk({name, "_conv_ce_count"}, 64'(nce), 64'(NA));
      chk({name, "_done_count"}, 64'(nd), 64'd1);
      prev_err = tmo;
    end
  endtask

  initial begin
    global_rst = 1'b1; start1 = 1'b0; start2 = 1'b0; act_avail = 1'b0; conv_end = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dut1", 64'(o1), 64'd0);
    chk("reset_dut2", 64'(o2), 64'd0);
    @(posedge clk); #1;
    global_rst = 1'b0;
    // idle: conv_end and act_avail are ignored
    conv_end = 1'b1; act_avail = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_ignores_inputs", 64'(o1), 64'd0);
    @(posedge clk); #1;
    conv_end = 1'b0;

    run_pass("basic", 0, 0, 5, 1'b0, -1);
    run_pass("stall", 0, 1, DMAX, 1'b0, -1);
    run_pass("timeout", 0, 0, -1, 1'b0, -1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err_sticky_idle", 64'(o1.err_timeout), 64'd1);
    @(posedge clk); #1;
    run_pass("glitch", 0, 2, int'($urandom_range(1, 63)), 1'b1, -1);
    run_pass("abort", 0, 0, 5, 1'b0, 1000);
    run_pass("clean", 0, 0, 5, 1'b0, -1);
    run_pass("lat2", 1, 2, int'($urandom_range(1, 63)), 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
